cla_seq_ctrl: RTL and testbench



---
 rtl/cla_seq_ctrl.sv | 160 ++++++++++++++++
 tb/tb_cla_seq_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_seq_ctrl.sv
// Sequencer that time-multiplexes one external 4-bit CLA slice to add/subtract NIB nibbles.
// Optional build macro CLA_SEQ_SAT_EN saturates the result on signed overflow.
module cla_seq_ctrl #(
  parameter int unsigned NIB = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [4*NIB-1:0]   req_a,
  input  logic [4*NIB-1:0]   req_b,
  input  logic               req_sub,
  output logic [3:0]         slice_a,
  output logic [3:0]         slice_b,
  output logic               slice_cin,
  input  logic [3:0]         slice_sum,
  input  logic               slice_cout,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [4*NIB-1:0]   resp_sum,
  output logic               resp_ovfl,
  output logic               resp_zero,
  output logic               resp_neg
);

  localparam int unsigned W  = 4 * NIB;
  localparam int unsigned CW = $clog2(NIB);
  localparam logic [CW-1:0] LastCnt = CW'(NIB - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  raw_q, raw_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          ovfl_q, ovfl_d;
  logic          zero_q, zero_d;
  logic          neg_q, neg_d;
  logic          ovfl_n;
  logic [W-1:0]  fin;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (req_valid) state_d = StRun;
      StRun:  if (cnt_q == LastCnt) state_d = StDone;
      StDone: if (resp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshake and slice outputs; the slice is held quiet outside RUN
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    slice_a    = 4'h0;
    slice_b    = 4'h0;
    slice_cin  = 1'b0;
    unique case (state_q)
      StIdle: req_ready = 1'b1;
      StRun: begin
        slice_a   = a_q[4*cnt_q +: 4];
        slice_b   = b_q[4*cnt_q +: 4];
        slice_cin = carry_q;
      end
      StDone: resp_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-state: operand capture, nibble accumulation, final flags
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    raw_d   = raw_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    ovfl_d  = ovfl_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    ovfl_n  = 1'b0;
    fin     = '0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          a_d     = req_a;
          b_d     = req_sub ? ~req_b : req_b;
          carry_d = req_sub;
          cnt_d   = '0;
          raw_d   = '0;
        end
      end
      StRun: begin
        raw_d[4*cnt_q +: 4] = slice_sum;
        carry_d             = slice_cout;
        cnt_d               = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          // Signed overflow from operand signs; top carry-out deliberately ignored
          ovfl_n = (a_q[W-1] == b_q[W-1]) && (raw_d[W-1] != a_q[W-1]);
          fin    = raw_d;
`ifdef CLA_SEQ_SAT_EN
          if (ovfl_n) begin
            fin = a_q[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
          end
`else
`endif
          sum_d  = fin;
          ovfl_d = ovfl_n;
          zero_d = (fin == '0);
          neg_d  = fin[W-1];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      raw_q   <= '0;
      sum_q   <= '0;
      ovfl_q  <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      raw_q   <= raw_d;
      sum_q   <= sum_d;
      ovfl_q  <= ovfl_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
    end
  end

  assign resp_sum  = sum_q;
  assign resp_ovfl = ovfl_q;
  assign resp_zero = zero_q;
  assign resp_neg  = neg_q;

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Scoreboard bench for cla_seq_ctrl: driver queues hand-computed results, monitor checks responses.
module tb_cla_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        req_sub;
  logic [3:0]  slice_a;
  logic [3:0]  slice_b;
  logic        slice_cin;
  logic [3:0]  slice_sum;
  logic        slice_cout;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_sum;
  logic        resp_ovfl;
  logic        resp_zero;
  logic        resp_neg;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [15:0] sum;
    logic        ovfl;
    logic        zero;
    logic        neg;
    bit          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];

  cla_seq_ctrl #(.NIB(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_sub    (req_sub),
    .slice_a    (slice_a),
    .slice_b    (slice_b),
    .slice_cin  (slice_cin),
    .slice_sum  (slice_sum),
    .slice_cout (slice_cout),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_sum   (resp_sum),
    .resp_ovfl  (resp_ovfl),
    .resp_zero  (resp_zero),
    .resp_neg   (resp_neg)
  );

  // Behavioural 4-bit slice
  logic [4:0] slice_full;
  assign slice_full = {1'b0, slice_a} + {1'b0, slice_b} + {4'b0, slice_cin};
  assign slice_sum  = slice_full[3:0];
  assign slice_cout = slice_full[4];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic push_exp(input logic [15:0] s, input logic o, input logic z, input logic n,
                          input bit lat, input int acc);
    exp_t e;
    e.sum  = s;
    e.ovfl = o;
    e.zero = z;
    e.neg  = n;
    e.lat  = lat;
    e.acc  = acc;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic sub,
                       input bit push, input logic [15:0] es, input logic eo,
                       input logic ez, input logic en, input bit lat);
    int n;
    @(negedge clk);
    req_a     = a;
    req_b     = b;
    req_sub   = sub;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1");
    end else if (push) begin
      push_exp(es, eo, ez, en, lat, cyc);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Monitor: pops expectations on each completed response, checks hold stability under backpressure
  initial begin : monitor
    logic [18:0] held;
    bit          have_held;
    exp_t        e;
    have_held = 0;
    held      = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        have_held = 0;
      end else if (resp_valid) begin
        chk("req_ready_in_done", {31'b0, req_ready}, 32'd0);
        chk("slice_quiet_done", {23'b0, slice_a, slice_b, slice_cin}, 32'd0);
        if (!resp_ready) begin
          if (have_held) begin
            chk("hold_stable", {13'b0, resp_sum, resp_ovfl, resp_zero, resp_neg},
                {13'b0, held});
          end else begin
            held      = {resp_sum, resp_ovfl, resp_zero, resp_neg};
            have_held = 1;
          end
        end else begin
          have_held = 0;
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_resp: got sum=%h expected no response", resp_sum);
          end else begin
            e = sb.pop_front();
            chk("resp_sum", {16'b0, resp_sum}, {16'b0, e.sum});
            chk("resp_ovfl", {31'b0, resp_ovfl}, {31'b0, e.ovfl});
            chk("resp_zero", {31'b0, resp_zero}, {31'b0, e.zero});
            chk("resp_neg", {31'b0, resp_neg}, {31'b0, e.neg});
            if (e.lat) chk("latency", cyc - e.acc, 32'd5);
          end
        end
      end
    end
  end

  initial begin : driver
    int n;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_a      = '0;
    req_b      = '0;
    req_sub    = 1'b0;
    resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_outputs", {13'b0, resp_sum, resp_ovfl, resp_zero, resp_neg}, 32'd0);
    chk("idle_slice_quiet", {23'b0, slice_a, slice_b, slice_cin}, 32'd0);

    // Carry ripples across nibbles 0-1, latency checked
    issue(16'h00FF, 16'h0001, 1'b0, 1, 16'h0100, 1'b0, 1'b0, 1'b0, 1);
    n = 0;
    while (sb.size() != 0 && n < 50) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);

    // Reset in the middle of RUN after two nibbles
    issue(16'h1234, 16'h1111, 1'b0, 0, 16'h0000, 1'b0, 1'b0, 1'b0, 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrun_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("midrun_req_ready", {31'b0, req_ready}, 32'd1);
    chk("midrun_resp_sum", {16'b0, resp_sum}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    issue(16'h0001, 16'h0001, 1'b0, 1, 16'h0002, 1'b0, 1'b0, 1'b0, 0);
    issue(16'h1234, 16'h1234, 1'b1, 1, 16'h0000, 1'b0, 1'b1, 1'b0, 0);
`ifdef CLA_SEQ_SAT_EN
    issue(16'h7FFF, 16'h0001, 1'b0, 1, 16'h7FFF, 1'b1, 1'b0, 1'b0, 0);
    issue(16'h8000, 16'h0001, 1'b1, 1, 16'h8000, 1'b1, 1'b0, 1'b1, 0);
`else
    issue(16'h7FFF, 16'h0001, 1'b0, 1, 16'h8000, 1'b1, 1'b0, 1'b1, 0);
    issue(16'h8000, 16'h0001, 1'b1, 1, 16'h7FFF, 1'b1, 1'b0, 1'b0, 0);
`endif
    issue(16'h5678, 16'h1234, 1'b1, 1, 16'h4444, 1'b0, 1'b0, 1'b0, 0);
    issue(16'h0000, 16'h0001, 1'b1, 1, 16'hFFFF, 1'b0, 1'b0, 1'b1, 0);

    // Backpressure with a pending request held during DONE
    n = 0;
    while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    resp_ready = 1'b0;
    issue(16'h0003, 16'h0004, 1'b0, 1, 16'h0007, 1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    req_valid = 1'b1;
    req_a     = 16'hAAAA;
    req_b     = 16'h5555;
    req_sub   = 1'b1;
    n = 0;
    while (!resp_valid && n < 50) begin @(negedge clk); n++; end
    if (!resp_valid) begin
      total++;
      bad++;
      $display("FAIL resp_timeout: got resp_valid=0 expected 1");
    end
    repeat (10) @(negedge clk);
    req_a   = 16'h0100;
    req_b   = 16'h0020;
    req_sub = 1'b0;
    @(negedge clk);
    push_exp(16'h0120, 1'b0, 1'b0, 1'b0, 0, 0);
    resp_ready = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL return_idle_timeout: got req_ready=0 expected 1");
    end
    @(posedge clk);
    #1 req_valid = 1'b0;

    n = 0;
    while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
